// File: rtl/jt12_ring_pkg.sv
// Shared helpers for jt12 channel rings: slot width and reset-pattern values.
// Pure constants and functions; no logic and no latency.
package jt12_ring_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // A one-channel index still needs a 1-bit port.
    function automatic int slot_w(input int stages);
        return (clog2(stages) < 1) ? 1 : clog2(stages);
    endfunction

    // Callers truncate the result to their own data width.
    function automatic int rst_val(input int k, input int base, input int step);
        return base + k * step;
    endfunction

endpackage

// File: rtl/jt12_ring_alu.sv
// Ring ALU: clear, load or add (wrap or saturate) with carry out; purely combinational.
// Zero latency and no flow control; the caller registers the result.
module jt12_ring_alu
    import jt12_ring_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SAT   = 0
) (
    input  logic [WIDTH-1:0] i_din,
    input  logic [WIDTH-1:0] i_add,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_clr,
    input  logic             i_load,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, i_din} + {1'b0, i_add};

    always_comb begin
        o_dout  = w_sum[WIDTH-1:0];
        o_carry = 1'b0;
        if (i_clr) begin
            o_dout = '0;
        end else if (i_load) begin
            o_dout = i_load_val;
        end else begin
            o_carry = w_sum[WIDTH];
            if (SAT != 0 && w_sum[WIDTH]) o_dout = '1;
        end
    end

endmodule

// File: rtl/jt12_ring_acc.sv
// Circular per-channel accumulator ring; ALU result appears on dout one enabled cycle later.
// clk_en low freezes every register (ring, slot, ovf); no other backpressure.
module jt12_ring_acc
    import jt12_ring_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STAGES   = 6,
    parameter int RST_BASE = 10,
    parameter int RST_STEP = 10,
    parameter int SAT      = 0,
    localparam int SW      = slot_w(STAGES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] add,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [SW-1:0]    slot,
    output logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic [SW-1:0]    dout_slot,
    output logic             ovf
);

    localparam logic [SW-1:0] LAST_SLOT = SW'(STAGES - 1);

    logic [WIDTH-1:0] r_ring [STAGES];
    logic [SW-1:0]    r_slot;
    logic [SW-1:0]    r_dout_slot;
    logic             r_ovf;
    logic [WIDTH-1:0] w_alu;
    logic             w_carry;

    jt12_ring_alu #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_alu (
        .i_din      (r_ring[0]),
        .i_add      (add),
        .i_load_val (load_val),
        .i_clr      (clr),
        .i_load     (load),
        .o_dout     (w_alu),
        .o_carry    (w_carry)
    );

    // Stage 0 is the ALU input; stage 1 holds the freshly computed channel value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ring[k] <= WIDTH'(rst_val(k, RST_BASE, RST_STEP));
            end
            r_slot      <= '0;
            r_dout_slot <= '0;
            r_ovf       <= 1'b0;
        end else if (clk_en) begin
            r_ring[0] <= r_ring[STAGES-1];
            r_ring[1] <= w_alu;
            for (int k = 1; k < STAGES - 1; k++) begin
                r_ring[k+1] <= r_ring[k];
            end
            r_slot      <= (r_slot == LAST_SLOT) ? '0 : r_slot + 1'b1;
            r_dout_slot <= r_slot;
            r_ovf       <= w_carry;
        end
    end

    assign slot      = r_slot;
    assign sync      = (r_slot == '0);
    assign dout      = r_ring[1];
    assign dout_slot = r_dout_slot;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_jt12_ring_acc.sv
// Directed plus random stimulus on three ring configurations, checked against a
// per-channel reference model through an expectation queue.
module tb_jt12_ring_acc;

    logic       clk = 1'b0;
    logic       rst, clk_en, load, clr;
    logic [7:0] add, load_val;

    logic [2:0] slot0, slot1, slot2, dslot0, dslot1, dslot2;
    logic       sync0, sync1, sync2, ovf0, ovf1, ovf2;
    logic [7:0] dout0, dout1, dout2;

    always #5 clk = ~clk;

    jt12_ring_acc u_wrap (
        .clk(clk), .rst(rst), .clk_en(clk_en), .add(add), .load(load),
        .load_val(load_val), .clr(clr), .slot(slot0), .sync(sync0),
        .dout(dout0), .dout_slot(dslot0), .ovf(ovf0)
    );

    jt12_ring_acc #(.SAT(1)) u_sat (
        .clk(clk), .rst(rst), .clk_en(clk_en), .add(add), .load(load),
        .load_val(load_val), .clr(clr), .slot(slot1), .sync(sync1),
        .dout(dout1), .dout_slot(dslot1), .ovf(ovf1)
    );

    jt12_ring_acc #(.STAGES(5)) u_five (
        .clk(clk), .rst(rst), .clk_en(clk_en), .add(add), .load(load),
        .load_val(load_val), .clr(clr), .slot(slot2), .sync(sync2),
        .dout(dout2), .dout_slot(dslot2), .ovf(ovf2)
    );

    typedef struct {
        int inst;
        int dout;
        int dslot;
        int slot;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    int st[3]  = '{6, 6, 5};
    int sat[3] = '{0, 1, 0};
    int m_ch[3][6];
    int m_slot[3], m_dout[3], m_dslot[3], m_ovf[3];
    int seq2[6] = '{11, 61, 51, 41, 31, 21};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int inst, input int f);
        logic [31:0] v;
        v = '0;
        case (inst)
            0: case (f) 0: v = {24'd0, dout0}; 1: v = {29'd0, dslot0}; 2: v = {29'd0, slot0};
                        3: v = {31'd0, ovf0}; default: v = {31'd0, sync0}; endcase
            1: case (f) 0: v = {24'd0, dout1}; 1: v = {29'd0, dslot1}; 2: v = {29'd0, slot1};
                        3: v = {31'd0, ovf1}; default: v = {31'd0, sync1}; endcase
            default: case (f) 0: v = {24'd0, dout2}; 1: v = {29'd0, dslot2}; 2: v = {29'd0, slot2};
                        3: v = {31'd0, ovf2}; default: v = {31'd0, sync2}; endcase
        endcase
        return v;
    endfunction

    // Channel c sits at ring stage (STAGES-c) mod STAGES after reset.
    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < st[i]; c++) m_ch[i][c] = (10 + ((st[i] - c) % st[i]) * 10) & 255;
            m_slot[i]  = 0;
            m_dslot[i] = 0;
            m_ovf[i]   = 0;
            m_dout[i]  = m_ch[i][st[i]-1];
        end
    endtask

    task automatic model_step(input int a, input bit ld, input int lv, input bit cl);
        int s, v, r, o;
        for (int i = 0; i < 3; i++) begin
            s = m_slot[i];
            v = m_ch[i][s];
            o = 0;
            if (cl) r = 0;
            else if (ld) r = lv;
            else begin
                r = v + a;
                if (r > 255) begin
                    o = 1;
                    r = sat[i] ? 255 : r - 256;
                end
            end
            m_ch[i][s] = r;
            m_dout[i]  = r;
            m_dslot[i] = s;
            m_ovf[i]   = o;
            m_slot[i]  = (s == st[i] - 1) ? 0 : s + 1;
        end
    endtask

    task automatic check_sb();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("u%0d dout", e.inst), obs(e.inst, 0), e.dout);
            chk($sformatf("u%0d dout_slot", e.inst), obs(e.inst, 1), e.dslot);
            chk($sformatf("u%0d slot", e.inst), obs(e.inst, 2), e.slot);
            chk($sformatf("u%0d ovf", e.inst), obs(e.inst, 3), e.ovf);
            chk($sformatf("u%0d sync", e.inst), obs(e.inst, 4), (e.slot == 0) ? 1 : 0);
        end
    endtask

    task automatic step(input bit en, input bit r, input int a, input bit ld, input int lv, input bit cl);
        exp_t e;
        clk_en   = en;
        rst      = r;
        add      = 8'(a);
        load     = ld;
        load_val = 8'(lv);
        clr      = cl;
        if (r) model_reset();
        else if (en) model_step(a, ld, lv, cl);
        for (int i = 0; i < 3; i++) begin
            e.inst = i; e.dout = m_dout[i]; e.dslot = m_dslot[i];
            e.slot = m_slot[i]; e.ovf = m_ovf[i];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check_sb();
    endtask

    task automatic run_to(input int s);
        for (int i = 0; i < 6 && m_slot[0] != s; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; add = '0; load = 1'b0; load_val = '0; clr = 1'b0;

        // Reset pattern
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("rst dout", {24'd0, dout0}, 20);
        chk("rst slot", {29'd0, slot0}, 0);
        chk("rst sync", {31'd0, sync0}, 1);
        chk("rst dout five", {24'd0, dout2}, 20);

        // Accumulate add=1 over two passes
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 1, 0, 0, 0);
            if (i < 6) begin
                chk("pass1 dout", {24'd0, dout0}, seq2[i]);
                chk("pass1 dout_slot", {29'd0, dslot0}, i);
            end
        end
        chk("pass2 last dout", {24'd0, dout0}, 22);

        // Overflow: wrap vs saturate
        run_to(2);
        step(1, 0, 0, 1, 255, 0);
        chk("load 255", {24'd0, dout0}, 255);
        run_to(2);
        step(1, 0, 1, 0, 0, 0);
        chk("wrap dout", {24'd0, dout0}, 0);
        chk("wrap ovf", {31'd0, ovf0}, 1);
        chk("sat dout", {24'd0, dout1}, 255);
        chk("sat ovf", {31'd0, ovf1}, 1);
        run_to(2);
        step(1, 0, 0, 0, 0, 0);
        chk("sat hold dout", {24'd0, dout1}, 255);
        chk("sat ovf clear", {31'd0, ovf1}, 0);

        // Enable gating; inputs during hold must be ignored
        step(1, 0, 3, 0, 0, 0);
        step(0, 0, 5, 1, 99, 0);
        step(0, 0, 7, 0, 0, 1);
        step(1, 0, 3, 0, 0, 0);

        // clr beats load
        run_to(3);
        step(1, 0, 0, 1, 77, 1);
        chk("clr wins", {24'd0, dout0}, 0);
        run_to(3);
        step(1, 0, 0, 1, 77, 0);
        chk("load only", {24'd0, dout0}, 77);
        chk("load slot", {29'd0, dslot0}, 3);

        // Mid-stream reset, then five-stage wrap
        step(1, 1, 9, 0, 0, 0);
        chk("mid rst dout", {24'd0, dout0}, 20);
        chk("mid rst slot", {29'd0, slot0}, 0);
        chk("mid rst sync", {31'd0, sync0}, 1);
        step(1, 0, 2, 0, 0, 0);
        chk("post rst dout", {24'd0, dout0}, 12);
        for (int i = 0; i < 3; i++) step(1, 0, 2, 0, 0, 0);
        chk("five slot4", {29'd0, slot2}, 4);
        step(1, 0, 2, 0, 0, 0);
        chk("five wrap", {29'd0, slot2}, 0);
        chk("five sync", {31'd0, sync2}, 1);

        // Random mix
        for (int i = 0; i < 80; i++) begin
            step(($urandom % 4) != 0, ($urandom % 50) == 0, int'($urandom % 256),
                 ($urandom % 8) == 0, int'($urandom % 256), ($urandom % 10) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
